ram_arbiter: RTL and testbench

Shares the 32-word x 3-bit single-port RAM between two independent requesters (port A and port B), one access per clock. After reset it first sweeps the whole RAM to a known value, then grants round-robin between requesters with a req/gnt handshake and a one-cycle read-return path. Sits directly in front of the RAM instance; it is the only module driving the RAM's address, data and write-enable.

---
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Arbiter in front of a single-port RAM: clears every word after reset, then
// grants two requesters round-robin with a one-cycle read-return path.
module ram_arbiter #(
    parameter int unsigned       ADDR_W    = 5,
    parameter int unsigned       DATA_W    = 3,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_last_a;
    logic              r_rvalid_a;
    logic              r_rvalid_b;

    logic              w_gnt_a;
    logic              w_gnt_b;
    logic [ADDR_W-1:0] w_ram_address;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_wren;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep counter, round-robin pointer, read-return flags, idle address hold
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_addr_hold <= '0;
            r_last_a    <= 1'b0;
            r_rvalid_a  <= 1'b0;
            r_rvalid_b  <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
            if (w_gnt_a) begin
                r_last_a <= 1'b1;
            end else if (w_gnt_b) begin
                r_last_a <= 1'b0;
            end
            r_rvalid_a  <= w_gnt_a & ~we_a;
            r_rvalid_b  <= w_gnt_b & ~we_b;
            r_addr_hold <= w_ram_address;
        end
    end

    // Next state, grant decision and RAM drive; reset masks every grant and write
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_a       = 1'b0;
        w_gnt_b       = 1'b0;
        w_ram_address = r_addr_hold;
        w_ram_data    = '0;
        w_ram_wren    = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_CLEAR: begin
                    w_ram_address = r_cnt;
                    w_ram_data    = CLEAR_VAL;
                    w_ram_wren    = 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    // A wins a tie only when B was granted most recently
                    if (req_a && (!req_b || !r_last_a)) begin
                        w_gnt_a       = 1'b1;
                        w_ram_address = addr_a;
                        w_ram_data    = wdata_a;
                        w_ram_wren    = we_a;
                    end else if (req_b) begin
                        w_gnt_b       = 1'b1;
                        w_ram_address = addr_b;
                        w_ram_data    = wdata_b;
                        w_ram_wren    = we_b;
                    end
                end
                default: w_state_nxt = ST_CLEAR;
            endcase
        end
    end

    assign gnt_a       = w_gnt_a;
    assign gnt_b       = w_gnt_b;
    assign busy        = reset | (r_state == ST_CLEAR);
    assign rvalid_a    = r_rvalid_a & ~reset;
    assign rvalid_b    = r_rvalid_b & ~reset;
    assign rdata       = (rvalid_a | rvalid_b) ? ram_q : '0;
    assign ram_address = w_ram_address;
    assign ram_data    = w_ram_data;
    assign ram_wren    = w_ram_wren;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked each
// cycle against a cycle-level model of the arbitration and memory contents.
module tb_ram_arbiter;

    localparam int unsigned       ADDR_W    = 5;
    localparam int unsigned       DATA_W    = 3;
    localparam int unsigned       DEPTH     = 32;
    localparam logic [DATA_W-1:0] CLEAR_VAL = '0;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_a, req_b, we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b, ram_address;
    logic [DATA_W-1:0] wdata_a, wdata_b, rdata, ram_data, ram_q;
    logic              gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_wren;

    logic [DATA_W-1:0] ram_mem [DEPTH];

    int n_total = 0;
    int n_pass  = 0;
    int n_cyc   = 0;

    // Reference model state
    bit                m_busy   = 1'b1;
    int                m_cnt    = 0;
    bit                m_last_a = 1'b0;
    bit                m_rv_a   = 1'b0;
    bit                m_rv_b   = 1'b0;
    logic [DATA_W-1:0] m_rd     = '0;
    int                m_hold   = 0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                g_a, g_b;

    always #5 clock = ~clock;

    ram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLEAR_VAL (CLEAR_VAL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_a       (req_a),
        .req_b       (req_b),
        .we_a        (we_a),
        .we_b        (we_b),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .wdata_a     (wdata_a),
        .wdata_b     (wdata_b),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .rvalid_a    (rvalid_a),
        .rvalid_b    (rvalid_b),
        .rdata       (rdata),
        .busy        (busy),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    // Single-port synchronous RAM the arbiter sits in front of
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, n_cyc, obs, exp);
    endtask

    task automatic idle();
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic set_a(input bit r, input bit w, input int a, input int d);
        req_a = r; we_a = w; addr_a = ADDR_W'(a); wdata_a = DATA_W'(d);
    endtask

    task automatic set_b(input bit r, input bit w, input int a, input int d);
        req_b = r; we_b = w; addr_b = ADDR_W'(a); wdata_b = DATA_W'(d);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge
    task automatic cyc();
        bit                e_busy, e_ga, e_gb, e_rva, e_rvb, e_wren;
        logic [DATA_W-1:0] e_rdata, e_data;
        int                e_addr;
        @(negedge clock);
        e_busy  = reset || m_busy;
        e_ga    = !e_busy && req_a && (!req_b || !m_last_a);
        e_gb    = !e_busy && req_b && !e_ga;
        e_rva   = !reset && m_rv_a;
        e_rvb   = !reset && m_rv_b;
        e_rdata = (e_rva || e_rvb) ? m_rd : '0;
        e_wren  = !reset && (m_busy || (e_ga && we_a) || (e_gb && we_b));
        e_addr  = m_busy ? m_cnt : e_ga ? int'(addr_a) : e_gb ? int'(addr_b) : m_hold;
        e_data  = m_busy ? CLEAR_VAL : e_ga ? wdata_a : wdata_b;
        check("busy", busy, e_busy);
        check("gnt_a", gnt_a, e_ga);
        check("gnt_b", gnt_b, e_gb);
        check("rvalid_a", rvalid_a, e_rva);
        check("rvalid_b", rvalid_b, e_rvb);
        check("rdata", rdata, e_rdata);
        if (!reset) begin
            check("ram_wren", ram_wren, e_wren);
            check("ram_address", ram_address, 8'(e_addr));
        end
        if (e_wren) check("ram_data", ram_data, e_data);
        g_a = e_ga;
        g_b = e_gb;
        @(posedge clock);
        n_cyc++;
        if (reset) begin
            m_busy = 1'b1; m_cnt = 0; m_last_a = 1'b0; m_rv_a = 1'b0; m_rv_b = 1'b0;
        end else begin
            m_rv_a = e_ga && !we_a;
            m_rv_b = e_gb && !we_b;
            m_hold = e_addr;
            if (m_busy) begin
                if (m_cnt == DEPTH - 1) begin
                    m_busy = 1'b0;
                    foreach (m_mem[i]) m_mem[i] = CLEAR_VAL;
                end
                m_cnt++;
            end else if (e_ga || e_gb) begin
                m_last_a = e_ga;
                if (e_ga ? we_a : we_b) m_mem[e_addr] = e_data;
                else                    m_rd = m_mem[e_addr];
            end
        end
        #1;
    endtask

    // Random traffic obeying the hold-until-grant protocol, optional random resets
    task automatic rand_phase(input int n, input bit with_rst);
        bit pa = 1'b0;
        bit pb = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (pa && $urandom_range(7) == 0) pa = 1'b0;
            else if (!pa && $urandom_range(1) == 1) begin
                pa = 1'b1;
                set_a(1'b1, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(7));
            end
            if (pb && $urandom_range(7) == 0) pb = 1'b0;
            else if (!pb && $urandom_range(1) == 1) begin
                pb = 1'b1;
                set_b(1'b1, 1'($urandom_range(1)), $urandom_range(7), $urandom_range(7));
            end
            req_a = pa;
            req_b = pb;
            reset = with_rst && ($urandom_range(99) == 0);
            cyc();
            if (g_a || reset) pa = 1'b0;
            if (g_b || reset) pb = 1'b0;
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        int rd_addrs [3];
        rd_addrs = '{0, 17, 31};
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;

        // Post-reset sweep of all 32 words
        repeat (DEPTH) cyc();
        check("sweep_done_busy", busy, 1'b0);

        // Cleared contents read back through port A
        foreach (rd_addrs[k]) begin
            set_a(1'b1, 1'b0, rd_addrs[k], 0);
            cyc();
            idle();
            check("clear_rvalid_a", rvalid_a, 1'b1);
            check("clear_rdata", rdata, 8'd0);
            cyc();
        end

        // Write then immediate read of the same address
        set_a(1'b1, 1'b1, 2, 4);
        cyc();
        set_a(1'b1, 1'b0, 2, 0);
        cyc();
        idle();
        check("wr_rd_rvalid_a", rvalid_a, 1'b1);
        check("wr_rd_rdata", rdata, 8'd4);
        check("wr_rd_rvalid_b", rvalid_b, 1'b0);
        cyc();

        // Both ports requesting continuously must alternate
        set_a(1'b1, 1'b1, 5, 3);
        cyc();
        idle();
        set_b(1'b1, 1'b1, 9, 6);
        cyc();
        set_a(1'b1, 1'b0, 5, 0);
        set_b(1'b1, 1'b0, 9, 0);
        repeat (6) cyc();
        idle();
        cyc();
        cyc();

        // B writes the top word, A reads it on the very next cycle
        set_b(1'b1, 1'b1, 31, 7);
        cyc();
        idle();
        set_a(1'b1, 1'b0, 31, 0);
        cyc();
        idle();
        check("raw_rvalid_a", rvalid_a, 1'b1);
        check("raw_rdata", rdata, 8'd7);
        cyc();

        rand_phase(300, 1'b0);

        // Reset lands on the cycle the read data would return
        set_a(1'b1, 1'b0, 17, 0);
        cyc();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_rvalid_a", rvalid_a, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_sweep_addr", ram_address, 8'd0);

        // Request raised mid-sweep waits for the sweep to finish
        for (int c = 0; c < int'(DEPTH); c++) begin
            if (c == 10) set_b(1'b1, 1'b1, 3, 5);
            cyc();
        end
        check("late_busy", busy, 1'b0);
        check("late_gnt_b", gnt_b, 1'b1);
        check("late_addr", ram_address, 8'd3);
        cyc();
        idle();
        set_a(1'b1, 1'b0, 3, 0);
        cyc();
        idle();
        check("late_rdata", rdata, 8'd5);
        cyc();

        rand_phase(400, 1'b1);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
